dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single data-memory port.
- Port C is the pipeline MEM stage; port D is the DMA/program-loader.
- One transaction in flight at a time. Fixed priority to C, with a starvation bound that forces a D grant.
- Drives the memory-side MemRead/MemWrite/a/wd/Funct3 signals and returns read data with a valid pulse to the owning requester.

Parameters:
- DM_ADDRESS, 9, byte-address width of the data memory.
- DATA_W, 32, data width.
- RD_LAT, 1, cycles the memory controls are held before rd is sampled (1..4).
- STARVE_MAX, 4, consecutive C grants while D is requesting before D is forced (1..15).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- c_req  in  1  port C request; level, held until c_gnt.
- c_we  in  1  port C store(1)/load(0).
- c_addr  in  DM_ADDRESS  port C byte address.
- c_wdata  in  DATA_W  port C store data.
- c_funct3  in  3  port C load/store size code (RISC-V funct3).
- c_gnt  out  1  one-cycle pulse; C fields are captured this cycle.
- c_rvalid  out  1  one-cycle completion pulse for C.
- c_rdata  out  DATA_W  load data for C; valid with c_rvalid.
- c_err  out  1  error flag, valid with c_rvalid.
- d_req, d_we, d_addr, d_wdata, d_funct3, d_gnt, d_rvalid, d_rdata, d_err: same as the port C signals, for port D.
- MemRead  out  1  to memory.
- MemWrite  out  1  to memory.
- a  out  DM_ADDRESS  to memory.
- wd  out  DATA_W  to memory.
- Funct3  out  3  to memory.
- rd  in  DATA_W  read data from memory.

Behaviour:
- Reset: when rst_n=0 at a rising edge, all outputs are 0, state is IDLE, starvation count is 0 and owner is cleared. This applies mid-transaction too: the transaction is dropped and no rvalid is issued.
- State IDLE:
  - If any request is present, pick a winner.
  - Assert its gnt for one cycle, latch we/addr/wdata/funct3/owner, and go to BUSY.
- Arbitration:
  - Winner is C if c_req and not (d_req and starve_cnt==STARVE_MAX); otherwise D if d_req.
  - starve_cnt increments, saturating at STARVE_MAX, when C wins while d_req=1.
  - starve_cnt clears when D wins.
  - starve_cnt is unchanged when C wins with d_req=0.
- State BUSY, lasting RD_LAT cycles:
  - MemRead=~we_l and MemWrite=we_l; a, wd and Funct3 come from the latched values. All are registered and stable for the whole phase.
  - On the last BUSY cycle, rd is sampled into the owner's rdata register; go to RESP.
- State RESP, one cycle:
  - The owner's rvalid=1.
  - rdata is the sampled rd for loads and 0 for stores.
  - MemRead=MemWrite=0.
  - Next state is IDLE.
- No gnt is asserted in BUSY or RESP. A request held or raised then waits for IDLE.
- Latency: gnt at cycle T, memory controls T+1..T+RD_LAT, rvalid at T+RD_LAT+1. Back-to-back throughput is one access per RD_LAT+2 cycles.
- A request dropped before gnt is ignored. A request still high in the cycle after its gnt counts as a new request.
- Outside BUSY, MemRead, MemWrite, a, wd and Funct3 are all 0.
- The non-owner's rvalid, rdata and err are always 0.
- c_err and d_err are 0 unless the optional feature is enabled.

Optional Feature:
- Macro: DMEM_ARB_ALIGN_CHECK_EN.
- Defined:
  - In IDLE, the winner's access is checked against its size code:
    - funct3[1:0]==2'b01 (half) with addr[0]=1 is misaligned.
    - funct3[1:0]==2'b10 (word) with addr[1:0]!=0 is misaligned.
  - A misaligned access still receives gnt and starvation accounting.
  - It skips BUSY (no MemRead/MemWrite) and goes straight to RESP with rvalid=1, err=1, rdata=0. Latency is gnt at T, rvalid at T+1.
- Not defined: no check is performed; err outputs are tied 0; all accesses go through BUSY.

Test Plan:
- Single C load: c_req, c_we=0, c_addr=0x010, funct3=3'b010, rd=0xDEADBEEF, RD_LAT=1.
  - Expect c_gnt at T, MemRead=1 with a=0x010 at T+1, c_rvalid=1 with c_rdata=0xDEADBEEF at T+2.
  - d_* outputs stay 0.
- Single D store: d_we=1, d_addr=0x044, d_wdata=0x12345678, funct3=3'b010.
  - Expect MemWrite=1, wd=0x12345678, Funct3=3'b010 for exactly RD_LAT cycles, then d_rvalid=1, d_rdata=0.
- Starvation, STARVE_MAX=4: c_req and d_req held high continuously.
  - Expect grant order C,C,C,C,D,C,C,C,C,D; starve_cnt returns to 0 after each D grant.
- Reset mid-op: assert rst_n=0 during BUSY of a C load.
  - Expect all outputs 0 on the next edge and no c_rvalid.
  - After release with c_req still high: a fresh c_gnt.
- Back-to-back with RD_LAT=3: c_req held for two loads.
  - Expect the second c_gnt exactly 5 cycles after the first, with no gnt during BUSY or RESP.
- DMEM_ARB_ALIGN_CHECK_EN defined: C load, funct3=3'b010, addr=0x013.
  - Expect c_gnt at T, c_rvalid=1 with c_err=1 and c_rdata=0 at T+1, MemRead never asserted.
  - Same stimulus with the macro undefined: a normal access with c_err=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single data-memory port (C = MEM stage, D = DMA/loader).
// Optional misalignment trap enabled by defining DMEM_ARB_ALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for a request; winner gets gnt and its fields are latched
// BUSY  | memory controls driven from latched fields for RD_LAT cycles
// RESP  | one-cycle rvalid (and err) to the owning requester
module dmem_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [DM_ADDRESS-1:0] c_addr,
    input  logic [DATA_W-1:0]     c_wdata,
    input  logic [2:0]            c_funct3,
    output logic                  c_gnt,
    output logic                  c_rvalid,
    output logic [DATA_W-1:0]     c_rdata,
    output logic                  c_err,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DM_ADDRESS-1:0] d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [2:0]            d_funct3,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_err,

    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [DM_ADDRESS-1:0] a,
    output logic [DATA_W-1:0]     wd,
    output logic [2:0]            Funct3,
    input  logic [DATA_W-1:0]     rd
);

    localparam int LAT_W = 2;
    localparam int STV_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [STV_W-1:0]        starve_q, starve_d;
    logic                    owner_q, owner_d;   // 0 = C, 1 = D
    logic                    we_q, we_d;
    logic [DM_ADDRESS-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [2:0]              f3_q, f3_d;
    logic [LAT_W-1:0]        lat_q, lat_d;

    logic                    mem_rd_q, mem_rd_d;
    logic                    mem_wr_q, mem_wr_d;
    logic [DM_ADDRESS-1:0]   a_q, a_d;
    logic [DATA_W-1:0]       wd_q, wd_d;
    logic [2:0]              f3o_q, f3o_d;

    logic                    c_rvalid_q, c_rvalid_d;
    logic                    d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0]       c_rdata_q, c_rdata_d;
    logic [DATA_W-1:0]       d_rdata_q, d_rdata_d;
    logic                    c_err_q, c_err_d;
    logic                    d_err_q, d_err_d;

    logic                    c_gnt_c, d_gnt_c;
    logic                    force_d, c_win, d_win;
    logic                    win_we;
    logic [DM_ADDRESS-1:0]   win_addr;
    logic [DATA_W-1:0]       win_wdata;
    logic [2:0]              win_f3;
    logic                    win_misalign;

    // D is forced only once C has won STARVE_MAX times in a row against it
    assign force_d   = d_req && (starve_q == STV_W'(STARVE_MAX));
    assign c_win     = c_req && !force_d;
    assign d_win     = d_req && !c_win;

    assign win_we    = c_win ? c_we     : d_we;
    assign win_addr  = c_win ? c_addr   : d_addr;
    assign win_wdata = c_win ? c_wdata  : d_wdata;
    assign win_f3    = c_win ? c_funct3 : d_funct3;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    assign win_misalign = ((win_f3[1:0] == 2'b01) && win_addr[0]) ||
                          ((win_f3[1:0] == 2'b10) && (win_addr[1:0] != 2'b00));
`else
    assign win_misalign = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        f3_d       = f3_q;
        lat_d      = lat_q;
        mem_rd_d   = 1'b0;
        mem_wr_d   = 1'b0;
        a_d        = '0;
        wd_d       = '0;
        f3o_d      = '0;
        c_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        c_rdata_d  = '0;
        d_rdata_d  = '0;
        c_err_d    = 1'b0;
        d_err_d    = 1'b0;
        c_gnt_c    = 1'b0;
        d_gnt_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (c_win || d_win) begin
                    c_gnt_c = c_win;
                    d_gnt_c = d_win;
                    owner_d = d_win;
                    we_d    = win_we;
                    addr_d  = win_addr;
                    wdata_d = win_wdata;
                    f3_d    = win_f3;

                    if (d_win) begin
                        starve_d = '0;
                    end else if (d_req && (starve_q != STV_W'(STARVE_MAX))) begin
                        starve_d = starve_q + STV_W'(1);
                    end

                    if (win_misalign) begin
                        state_d    = S_RESP;
                        c_rvalid_d = c_win;
                        d_rvalid_d = d_win;
                        c_err_d    = c_win;
                        d_err_d    = d_win;
                    end else begin
                        state_d  = S_BUSY;
                        lat_d    = LAT_W'(RD_LAT - 1);
                        mem_rd_d = ~win_we;
                        mem_wr_d = win_we;
                        a_d      = win_addr;
                        wd_d     = win_wdata;
                        f3o_d    = win_f3;
                    end
                end
            end

            S_BUSY: begin
                if (lat_q == '0) begin
                    state_d    = S_RESP;
                    c_rvalid_d = ~owner_q;
                    d_rvalid_d = owner_q;
                    if (!we_q) begin
                        c_rdata_d = owner_q ? '0 : rd;
                        d_rdata_d = owner_q ? rd : '0;
                    end
                end else begin
                    lat_d    = lat_q - LAT_W'(1);
                    mem_rd_d = ~we_q;
                    mem_wr_d = we_q;
                    a_d      = addr_q;
                    wd_d     = wdata_q;
                    f3o_d    = f3_q;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            starve_q   <= '0;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            f3_q       <= '0;
            lat_q      <= '0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            a_q        <= '0;
            wd_q       <= '0;
            f3o_q      <= '0;
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
            d_rdata_q  <= '0;
            c_err_q    <= 1'b0;
            d_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            f3_q       <= f3_d;
            lat_q      <= lat_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            a_q        <= a_d;
            wd_q       <= wd_d;
            f3o_q      <= f3o_d;
            c_rvalid_q <= c_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            c_rdata_q  <= c_rdata_d;
            d_rdata_q  <= d_rdata_d;
            c_err_q    <= c_err_d;
            d_err_q    <= d_err_d;
        end
    end

    // gnt is combinational in IDLE; masking with rst_n keeps it low while reset is held
    assign c_gnt    = c_gnt_c & rst_n;
    assign d_gnt    = d_gnt_c & rst_n;
    assign c_rvalid = c_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign c_rdata  = c_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign c_err    = c_err_q;
    assign d_err    = d_err_q;
    assign MemRead  = mem_rd_q;
    assign MemWrite = mem_wr_q;
    assign a        = a_q;
    assign wd       = wd_q;
    assign Funct3   = f3o_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: RD_LAT=1 instance for most checks, RD_LAT=3 instance for back-to-back spacing.
module tb_dmem_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          c_req, c_we, d_req, d_we;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wdata, d_wdata, rd;
    logic [2:0]    c_funct3, d_funct3;

    logic          c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
    logic [DW-1:0] c_rdata, d_rdata, wd;
    logic          MemRead, MemWrite;
    logic [AW-1:0] a;
    logic [2:0]    Funct3;

    logic          c_req3, d_req3;
    logic          c_gnt3, c_rvalid3, c_err3, d_gnt3, d_rvalid3, d_err3;
    logic [DW-1:0] c_rdata3, d_rdata3, wd3;
    logic          MemRead3, MemWrite3;
    logic [AW-1:0] a3;
    logic [2:0]    Funct33;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .RD_LAT(1), .STARVE_MAX(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_funct3(c_funct3),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .MemRead(MemRead), .MemWrite(MemWrite), .a(a), .wd(wd), .Funct3(Funct3), .rd(rd)
    );

    dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .RD_LAT(3), .STARVE_MAX(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req3), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_funct3(c_funct3),
        .c_gnt(c_gnt3), .c_rvalid(c_rvalid3), .c_rdata(c_rdata3), .c_err(c_err3),
        .d_req(d_req3), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
        .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3), .d_err(d_err3),
        .MemRead(MemRead3), .MemWrite(MemWrite3), .a(a3), .wd(wd3), .Funct3(Funct33), .rd(rd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int        waited;
        logic      exp_d;
        logic [11:0] gnt_v, mrd_v, rv_v;

        rst_n = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = '0; c_wdata = '0; c_funct3 = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_funct3 = '0;
        c_req3 = 1'b0; d_req3 = 1'b0; rd = '0;

        // reset state, with a request pending that must not be granted
        step(); step();
        chk("rst_c_gnt",    c_gnt,    0);
        chk("rst_memread",  MemRead,  0);
        chk("rst_memwrite", MemWrite, 0);
        chk("rst_a",        a,        0);
        chk("rst_c_rvalid", c_rvalid, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        c_req = 1'b0;
        rst_n = 1'b1;
        step();

        // single C load
        c_req = 1'b1; c_we = 1'b0; c_addr = 9'h010; c_funct3 = 3'b010; rd = 32'hDEADBEEF;
        #1;
        chk("cl_c_gnt", c_gnt, 1);
        chk("cl_d_gnt", d_gnt, 0);
        step();
        c_req = 1'b0;
        chk("cl_memread",  MemRead,  1);
        chk("cl_memwrite", MemWrite, 0);
        chk("cl_a",        a,        32'h010);
        chk("cl_funct3",   Funct3,   3'b010);
        chk("cl_busy_gnt", c_gnt,    0);
        step();
        chk("cl_c_rvalid", c_rvalid, 1);
        chk("cl_c_rdata",  c_rdata,  32'hDEADBEEF);
        chk("cl_c_err",    c_err,    0);
        chk("cl_d_rvalid", d_rvalid, 0);
        chk("cl_d_rdata",  d_rdata,  0);
        chk("cl_resp_mrd", MemRead,  0);
        step();
        chk("cl_rvalid_off", c_rvalid, 0);

        // single D store
        d_req = 1'b1; d_we = 1'b1; d_addr = 9'h044; d_wdata = 32'h12345678; d_funct3 = 3'b010;
        rd = 32'hA5A5A5A5;
        #1;
        chk("ds_d_gnt", d_gnt, 1);
        chk("ds_c_gnt", c_gnt, 0);
        step();
        d_req = 1'b0;
        chk("ds_memwrite", MemWrite, 1);
        chk("ds_memread",  MemRead,  0);
        chk("ds_wd",       wd,       32'h12345678);
        chk("ds_a",        a,        32'h044);
        chk("ds_funct3",   Funct3,   3'b010);
        step();
        chk("ds_memwrite_off", MemWrite, 0);
        chk("ds_d_rvalid",     d_rvalid, 1);
        chk("ds_d_rdata",      d_rdata,  0);
        chk("ds_c_rvalid",     c_rvalid, 0);
        step();

        // starvation: C,C,C,C,D repeating
        c_req = 1'b1; c_we = 1'b0; d_req = 1'b1; d_we = 1'b0;
        #1;
        for (int g = 0; g < 10; g++) begin
            waited = 0;
            while (!(c_gnt || d_gnt) && waited < 10) begin
                step();
                waited++;
            end
            exp_d = ((g % 5) == 4);
            chk($sformatf("stv_wait%0d", g), waited, (g == 0) ? 0 : 2);
            chk($sformatf("stv_dgnt%0d", g), d_gnt, exp_d);
            chk($sformatf("stv_cgnt%0d", g), c_gnt, !exp_d);
            step();
        end
        c_req = 1'b0; d_req = 1'b0;
        repeat (4) step();

        // reset during BUSY of a C load
        c_req = 1'b1; c_we = 1'b0; c_addr = 9'h020; c_funct3 = 3'b010; rd = 32'h0BADF00D;
        #1;
        chk("rm_c_gnt", c_gnt, 1);
        step();
        chk("rm_busy_mrd", MemRead, 1);
        rst_n = 1'b0;
        step();
        chk("rm_memread", MemRead,  0);
        chk("rm_a",       a,        0);
        chk("rm_c_rvalid", c_rvalid, 0);
        chk("rm_c_gnt_low", c_gnt,  0);
        step();
        chk("rm_c_rvalid2", c_rvalid, 0);
        rst_n = 1'b1;
        #1;
        chk("rm_regrant", c_gnt, 1);
        step();
        c_req = 1'b0;
        repeat (3) step();

        // back-to-back on the RD_LAT=3 instance
        c_we = 1'b0; c_addr = 9'h030; rd = 32'h11223344;
        c_req3 = 1'b1;
        #1;
        gnt_v = '0; mrd_v = '0; rv_v = '0;
        for (int i = 0; i < 12; i++) begin
            gnt_v[i] = c_gnt3;
            mrd_v[i] = MemRead3;
            rv_v[i]  = c_rvalid3;
            step();
        end
        c_req3 = 1'b0;
        chk("b2b_gnt_pattern",  gnt_v, 12'h421);
        chk("b2b_mrd_pattern",  mrd_v, 12'h9CE);
        chk("b2b_rv_pattern",   rv_v,  12'h210);
        chk("b2b_rdata",        c_rdata3, 0);
        repeat (6) step();

        // misaligned word load
        c_req = 1'b1; c_we = 1'b0; c_addr = 9'h013; c_funct3 = 3'b010; rd = 32'hCAFEF00D;
        #1;
        chk("al_c_gnt", c_gnt, 1);
        step();
        c_req = 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        chk("al_memread", MemRead,  0);
        chk("al_c_rvalid", c_rvalid, 1);
        chk("al_c_err",    c_err,    1);
        chk("al_c_rdata",  c_rdata,  0);
        chk("al_d_err",    d_err,    0);
        step();
        chk("al_memread2", MemRead, 0);
`else
        chk("al_memread", MemRead, 1);
        chk("al_a",       a,       32'h013);
        step();
        chk("al_c_rvalid", c_rvalid, 1);
        chk("al_c_err",    c_err,    0);
        chk("al_c_rdata",  c_rdata,  32'hCAFEF00D);
        chk("al_d_err",    d_err,    0);
`endif
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
